// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad and emits one debounced pulse with a key code per press
module keypad_scanner #(
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] keyboard_bus,
  output logic       key_pressed
);
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2, RELEASE = 2'd3;
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] r_sync1, r_sync2, r_rows, r_code, r_bus;
  logic [1:0] r_state, r_row;
  logic [SW-1:0] r_settle;
  logic [DW-1:0] r_deb;
  logic r_pulse;
  logic w_hit, w_match;
  logic [1:0] w_col, w_row_next;
  assign w_hit = r_sync2 != 4'hf;
  assign w_col = !r_sync2[0] ? 2'd0 : !r_sync2[1] ? 2'd1 : !r_sync2[2] ? 2'd2 : 2'd3;
  assign w_match = w_hit && w_col == r_code[1:0];
  assign w_row_next = r_row + 2'd1;
  assign rows = r_rows;
  assign keyboard_bus = r_bus;
  assign key_pressed = r_pulse;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 4'hf;
      r_sync2 <= 4'hf;
      r_state <= SCAN;
      r_row <= '0;
      r_rows <= 4'b1110;
      r_settle <= '0;
      r_deb <= '0;
      r_code <= '0;
      r_bus <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= columns;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      case (r_state)
        SCAN:
          if (r_settle != S_LAST) r_settle <= r_settle + 1'b1;
          else if (w_hit) begin
            r_code <= {r_row, w_col};
            r_deb <= '0;
            r_state <= DEBOUNCE;
          end else begin
            r_row <= w_row_next;
            r_rows <= ~(4'b1 << w_row_next);
            r_settle <= '0;
          end
        DEBOUNCE:
          if (!w_match) begin
            r_settle <= '0;
            r_state <= SCAN;
          end else begin
            r_deb <= r_deb + 1'b1;
            if (r_deb == D_LAST) begin
              r_bus <= r_code;
              r_pulse <= 1'b1;
              r_state <= HOLD;
            end
          end
        HOLD:
          if (!w_hit) begin
            r_deb <= '0;
            r_state <= RELEASE;
          end
        RELEASE:
          if (w_hit) r_state <= HOLD;
          else if (r_deb == D_LAST) begin
            r_row <= w_row_next;
            r_rows <= ~(4'b1 << w_row_next);
            r_settle <= '0;
            r_state <= SCAN;
          end else r_deb <= r_deb + 1'b1;
        default: r_state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus a procedural scan/debounce reference checked every cycle
module tb_keypad_scanner;
  localparam int S = 4, D = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic [3:0] columns, rows, keyboard_bus;
  logic key_pressed;
  logic [15:0] keys = '0;
  int n_cmp = 0, n_bad = 0, n_pulse = 0;
  logic chk_en = 1'b0;
  logic [3:0] e_rows = 4'b1110, e_bus = 4'h0;
  logic e_pulse = 1'b0;
  logic [3:0] m_s1 = 4'hf, m_s2 = 4'hf, m_cs = 4'hf;
  logic m_abort = 1'b0;

  keypad_scanner #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .columns(columns),
    .rows(rows), .keyboard_bus(keyboard_bus), .key_pressed(key_pressed)
  );

  always #5 clock = ~clock;

  always_comb begin
    columns = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) columns[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic hit(input logic [3:0] c);
    return c != 4'hf;
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (!c[i]) r = 2'(i);
    return r;
  endfunction

  // one model clock: m_cs is the synchronized column value seen during the cycle that just ended
  task automatic m_tick();
    @(posedge clock);
    m_cs = m_s2;
    m_s2 = m_s1;
    m_s1 = columns;
    e_pulse = 1'b0;
    if (!reset) begin
      m_abort = 1'b1;
      m_s1 = 4'hf;
      m_s2 = 4'hf;
      e_rows = 4'b1110;
      e_bus = 4'h0;
    end
  endtask

  initial begin : model
    logic [1:0] row, c;
    logic [3:0] code;
    int n;
    forever begin
      m_abort = 1'b0;
      row = 2'd0;
      while (!m_abort) begin
        for (int s = 0; s < S && !m_abort; s++) m_tick();
        if (m_abort) break;
        if (!hit(m_cs)) begin
          row++;
          e_rows = ~(4'b1 << row);
          continue;
        end
        c = low_col(m_cs);
        code = {row, c};
        n = 0;
        while (n < D && !m_abort) begin
          m_tick();
          if (m_abort || !hit(m_cs) || low_col(m_cs) != c) break;
          n++;
        end
        if (m_abort) break;
        if (n < D) continue;
        e_bus = code;
        e_pulse = 1'b1;
        do begin
          do m_tick(); while (!m_abort && hit(m_cs));
          n = 0;
          while (!m_abort && n < D) begin
            m_tick();
            if (m_abort || hit(m_cs)) break;
            n++;
          end
        end while (!m_abort && n < D);
        if (m_abort) break;
        row++;
        e_rows = ~(4'b1 << row);
      end
    end
  end

  always @(negedge clock) begin
    if (key_pressed === 1'b1) n_pulse++;
    if (chk_en) begin
      chk("rows", 32'(rows), 32'(e_rows));
      chk("bus", 32'(keyboard_bus), 32'(e_bus));
      chk("pulse", 32'(key_pressed), 32'(e_pulse));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    cyc(n);
    reset = 1'b1;
  endtask

  task automatic chk_pulses(input string tag, input int p0, input int exp);
    #1;
    chk(tag, 32'(n_pulse - p0), 32'(exp));
  endtask

  initial begin
    int p0, k, h;
    bit bnc;
    cyc(2);
    chk_en = 1'b1;
    reset = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc(1);
      chk("idle_rows", 32'(rows), 32'(4'(~(4'b1 << ((i / 4) % 4)))));
    end
    chk("idle_pulse", 32'(key_pressed), 32'd0);
    keys[9] = 1'b1;
    do_reset(2);
    cyc(15);
    chk("clean_pre", 32'(key_pressed), 32'd0);
    cyc(1);
    chk("clean_pulse", 32'(key_pressed), 32'd1);
    chk("clean_bus", 32'(keyboard_bus), 32'h9);
    chk("clean_rows", 32'(rows), 32'b1011);
    cyc(1);
    chk("clean_post", 32'(key_pressed), 32'd0);
    cyc(10);
    keys = '0;
    cyc(20);
    chk("clean_hold", 32'(keyboard_bus), 32'h9);
    p0 = n_pulse;
    for (int i = 0; i < 32; i++) begin
      keys[5] = ~keys[5];
      cyc(2);
    end
    chk_pulses("bounce_none", p0, 0);
    keys[5] = 1'b1;
    cyc(40);
    chk_pulses("bounce_one", p0, 1);
    chk("bounce_bus", 32'(keyboard_bus), 32'h5);
    keys = '0;
    cyc(20);
    keys[2] = 1'b1;
    keys[3] = 1'b1;
    keys[12] = 1'b1;
    do_reset(2);
    p0 = n_pulse;
    cyc(30);
    chk_pulses("multi_first", p0, 1);
    chk("multi_bus0", 32'(keyboard_bus), 32'h2);
    keys[2] = 1'b0;
    keys[3] = 1'b0;
    cyc(40);
    chk_pulses("multi_second", p0, 2);
    chk("multi_bus1", 32'(keyboard_bus), 32'hc);
    keys = '0;
    cyc(20);
    p0 = n_pulse;
    keys[6] = 1'b1;
    cyc(40);
    keys[6] = 1'b0;
    cyc(3);
    keys[6] = 1'b1;
    cyc(30);
    chk_pulses("rel_short", p0, 1);
    keys[6] = 1'b0;
    cyc(6);
    keys[6] = 1'b1;
    cyc(40);
    chk_pulses("rel_long", p0, 2);
    chk("rel_bus", 32'(keyboard_bus), 32'h6);
    keys = '0;
    cyc(20);
    keys[3] = 1'b1;
    do_reset(2);
    cyc(5);
    reset = 1'b0;
    cyc(1);
    chk("rst_deb_rows", 32'(rows), 32'b1110);
    chk("rst_deb_bus", 32'(keyboard_bus), 32'h0);
    chk("rst_deb_pulse", 32'(key_pressed), 32'd0);
    reset = 1'b1;
    cyc(8);
    chk("rst_pre_pulse", 32'(key_pressed), 32'd1);
    chk("rst_pre_bus", 32'(keyboard_bus), 32'h3);
    reset = 1'b0;
    cyc(1);
    chk("rst_pul_rows", 32'(rows), 32'b1110);
    chk("rst_pul_bus", 32'(keyboard_bus), 32'h0);
    chk("rst_pul_pulse", 32'(key_pressed), 32'd0);
    reset = 1'b1;
    keys = '0;
    cyc(4);
    chk("rst_restart", 32'(rows), 32'b1101);
    cyc(20);
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 15));
      h = int'($urandom_range(1, 40));
      bnc = ($urandom_range(0, 2) == 0);
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      for (int j = 0; j < h; j++) begin
        if (bnc) keys[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 3)));
        cyc(1);
      end
      keys = '0;
      cyc(int'($urandom_range(0, 30)));
    end
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
